// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the VGA frame-buffer write engine.
// Holds the command op-codes, default image geometry, the 8-bit colour
// field layout (blue[7:6], green[5:3], red[2:0]) and the FSM state encoding.
package fb_pkg;

    // Default image geometry and RAM shape
    localparam int IMG_W_DEF         = 75;
    localparam int IMG_H_DEF         = 75;
    localparam int RAM_ADDR_BITS_DEF = 13;
    localparam int RAM_WIDTH_DEF     = 8;

    // Width of every command coordinate field
    localparam int COORD_BITS = 7;

    // Command op-codes
    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Colour field bit positions inside one pixel
    localparam int BLUE_MSB  = 7;
    localparam int BLUE_LSB  = 6;
    localparam int GREEN_MSB = 5;
    localparam int GREEN_LSB = 3;
    localparam int RED_MSB   = 2;
    localparam int RED_LSB   = 0;

    // Write-engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLOT   = 2'd1,
        ST_FILL   = 2'd2,
        ST_FINISH = 2'd3
    } fb_state_t;

    // Build a pixel value from its blue/green/red components
    function automatic logic [7:0] pack_color(input logic [1:0] b,
                                              input logic [2:0] g,
                                              input logic [2:0] r);
        logic [7:0] c;
        c = '0;
        c[BLUE_MSB:BLUE_LSB]   = b;
        c[GREEN_MSB:GREEN_LSB] = g;
        c[RED_MSB:RED_LSB]     = r;
        return c;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: row-major pixel walker for the frame-buffer writer.
// On load it captures the (already clipped) rectangle corners and computes the
// first row base once with a multiply. After that, advance steps x by one
// inside a row and moves to the next row by adding IMG_W to the row base, so
// the per-pixel path contains only adders. addr_o is the address of the pixel
// currently presented; last_o flags the bottom-right pixel of the rectangle.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int IMG_W         = IMG_W_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  logic [COORD_BITS-1:0]    x_start_i,
    input  logic [COORD_BITS-1:0]    y_start_i,
    input  logic [COORD_BITS-1:0]    x_end_i,
    input  logic [COORD_BITS-1:0]    y_end_i,
    output logic [RAM_ADDR_BITS-1:0] addr_o,
    output logic                     last_o
);

    localparam logic [RAM_ADDR_BITS-1:0] ROW_STEP = RAM_ADDR_BITS'(IMG_W);

    logic [COORD_BITS-1:0]    x_q, x_d;
    logic [COORD_BITS-1:0]    y_q, y_d;
    logic [COORD_BITS-1:0]    x_start_q, x_start_d;
    logic [COORD_BITS-1:0]    x_end_q, x_end_d;
    logic [COORD_BITS-1:0]    y_end_q, y_end_d;
    logic [RAM_ADDR_BITS-1:0] row_base_q, row_base_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;

    logic row_end;

    assign row_end = (x_q == x_end_q);
    assign last_o  = row_end && (y_q == y_end_q);
    assign addr_o  = addr_q;

    // Next-state: capture a new rectangle on load, otherwise step through it
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load_i) begin
            x_d        = x_start_i;
            y_d        = y_start_i;
            x_start_d  = x_start_i;
            x_end_d    = x_end_i;
            y_end_d    = y_end_i;
            row_base_d = RAM_ADDR_BITS'(y_start_i) * ROW_STEP;
            addr_d     = row_base_d + RAM_ADDR_BITS'(x_start_i);
        end else if (advance_i) begin
            if (row_end) begin
                x_d        = x_start_q;
                y_d        = COORD_BITS'(y_q + 1'b1);
                row_base_d = row_base_q + ROW_STEP;
                addr_d     = row_base_q + ROW_STEP + RAM_ADDR_BITS'(x_start_q);
            end else begin
                x_d    = COORD_BITS'(x_q + 1'b1);
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Counter and address registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q        <= '0;
            y_q        <= '0;
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: turns plot / fill-rect / clear commands into a row-major
// stream of single-pixel writes into the 75x75 8-bit pixel RAM.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is a registered flag that is 1 only while idle and drops on the
// accepting edge, and every cmd_* field is captured on that same edge, so the
// source may change them freely afterwards.
//
// Optional feature, macro FB_WRITER_BLANK_HOLD_EN: pixel writes are allowed
// only while vidon is low. vidon is sampled on the clock edge that decides the
// next cycle's write; while it is high the engine holds its pixel with
// wr_en low, and that held pixel is the first one written once vidon falls.
module vga_fb_writer
    import fb_pkg::*;
#(
    parameter int IMG_W         = IMG_W_DEF,
    parameter int IMG_H         = IMG_H_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [COORD_BITS-1:0]    cmd_x0,
    input  logic [COORD_BITS-1:0]    cmd_y0,
    input  logic [COORD_BITS-1:0]    cmd_x1,
    input  logic [COORD_BITS-1:0]    cmd_y1,
    input  logic [RAM_WIDTH-1:0]     cmd_color,
    input  logic                     vidon,
    output logic                     wr_en,
    output logic [RAM_ADDR_BITS-1:0] wr_addr,
    output logic [RAM_WIDTH-1:0]     wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dbg_state
);

    localparam logic [COORD_BITS-1:0] W_LIM  = COORD_BITS'(IMG_W);
    localparam logic [COORD_BITS-1:0] H_LIM  = COORD_BITS'(IMG_H);
    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_W - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_H - 1);

    fb_state_t              state_q;
    logic                   cmd_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   wr_en_q;
    logic [RAM_WIDTH-1:0]   wr_data_q;

    // Decoded and clipped command corners
    logic [COORD_BITS-1:0]  sx0, sy0, sx1, sy1;
    logic [COORD_BITS-1:0]  cx1, cy1;
    logic                   rsvd_op;
    logic                   empty_cmd;

    logic                   accept;
    logic                   gen_advance;
    logic                   gen_last;
    logic                   write_ok;

`ifdef FB_WRITER_BLANK_HOLD_EN
    // Only write during blanking
    assign write_ok = ~vidon;
`else
    // vidon has no effect in this build
    logic vidon_unused;
    assign vidon_unused = vidon;
    assign write_ok     = 1'b1;
`endif

    assign accept      = cmd_valid && cmd_ready_q;
    // Step to the next pixel only once the current one has actually been written
    assign gen_advance = (state_q == ST_FILL) && wr_en_q && !gen_last;

    // Decode the op into a rectangle, clamp the far corner, detect empty commands
    always_comb begin
        sx0     = cmd_x0;
        sy0     = cmd_y0;
        sx1     = cmd_x1;
        sy1     = cmd_y1;
        rsvd_op = 1'b0;
        case (cmd_op)
            OP_PLOT: begin
                sx1 = cmd_x0;
                sy1 = cmd_y0;
            end
            OP_FILL: begin
                sx1 = cmd_x1;
                sy1 = cmd_y1;
            end
            OP_CLEAR: begin
                sx0 = '0;
                sy0 = '0;
                sx1 = X_LAST;
                sy1 = Y_LAST;
            end
            default: rsvd_op = 1'b1;
        endcase
        cx1       = (sx1 > X_LAST) ? X_LAST : sx1;
        cy1       = (sy1 > Y_LAST) ? Y_LAST : sy1;
        empty_cmd = rsvd_op || (sx0 >= W_LIM) || (sy0 >= H_LIM) ||
                    (sx0 > cx1) || (sy0 > cy1);
    end

    fb_addr_gen #(
        .IMG_W         (IMG_W),
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_addr_gen (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (accept),
        .advance_i (gen_advance),
        .x_start_i (sx0),
        .y_start_i (sy0),
        .x_end_i   (cx1),
        .y_end_i   (cy1),
        .addr_o    (wr_addr),
        .last_o    (gen_last)
    );

    // Command FSM with registered handshake, strobe and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        wr_data_q   <= cmd_color;
                        if (empty_cmd) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                            wr_en_q <= 1'b0;
                        end else begin
                            state_q <= (cmd_op == OP_PLOT) ? ST_PLOT : ST_FILL;
                            wr_en_q <= write_ok;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        wr_en_q     <= 1'b0;
                    end
                end
                ST_PLOT, ST_FILL: begin
                    if (wr_en_q && ((state_q == ST_PLOT) || gen_last)) begin
                        state_q <= ST_FINISH;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wr_en_q <= write_ok;
                        done_q  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    wr_en_q     <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    wr_en_q     <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

endmodule
